// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory image loader: FSM state
// encodings, default framing/status byte values and the byte-index width
// used to assemble 32-bit words from the byte stream.
package imem_loader_pkg;

    // State encodings are plain constants so they remain usable from
    // older tooling that does not accept enumerated types in ports.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_CSUM   = 3'd4;
    localparam state_t ST_ACK    = 3'd5;

    // Default framing and status bytes.
    localparam logic [7:0] MAGIC_DEFAULT   = 8'hA5;
    localparam logic [7:0] ACK_OK_DEFAULT  = 8'h4B;  // 'K'
    localparam logic [7:0] ACK_ERR_DEFAULT = 8'h45;  // 'E'

    // Four bytes per word -> two-bit byte index.
    localparam int BYTE_IDX_W = 2;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Receives a framed program image over a byte stream and writes it into the
// instruction memory, one 32-bit little-endian word per consecutive address
// starting at 0. Frame: MAGIC, LEN_LO, LEN_HI, N*4 data bytes, CSUM (mod-256
// sum of the data bytes). A single status byte is then offered to the
// transmitter and the CPU is held in reset for the whole load.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   rx_valid   in   one-cycle strobe, rx_data valid
//   rx_data    in   received byte
//   mem_ce     out  memory clock enable (only together with mem_wre)
//   mem_wre    out  one-cycle write pulse per completed word
//   mem_ad     out  word address
//   mem_din    out  write data
//   ack_valid  out  status byte available
//   ack_data   out  status byte (ACK_OK / ACK_ERR)
//   ack_ready  in   transmitter accepts the status byte
//   cpu_hold   out  high whenever a frame is in progress or being acknowledged
//   load_done  out  one-cycle pulse on the handshake of a successful load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W  = 11,
    parameter logic [7:0] MAGIC   = MAGIC_DEFAULT,
    parameter logic [7:0] ACK_OK  = ACK_OK_DEFAULT,
    parameter logic [7:0] ACK_ERR = ACK_ERR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [31:0]       mem_din,
    output logic              ack_valid,
    output logic [7:0]        ack_data,
    input  logic              ack_ready,
    output logic              cpu_hold,
    output logic              load_done
);

    // The word counter needs one extra bit so that a full-memory load
    // (len == 2^ADDR_W) can be counted without wrapping back to zero.
    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    state_t                  state_q,    state_d;
    logic [7:0]              len_lo_q,   len_lo_d;
    logic [CNT_W-1:0]        len_q,      len_d;
    logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]              csum_q,     csum_d;
    logic [23:0]             word_q,     word_d;     // first three bytes of the word
    logic                    wre_q,      wre_d;
    logic [ADDR_W-1:0]       ad_q,       ad_d;
    logic [31:0]             din_q,      din_d;
    logic [7:0]              ack_data_q, ack_data_d;
    logic                    ok_q,       ok_d;

    logic [16:0]             len_ext;

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        word_d     = word_q;
        wre_d      = 1'b0;          // write strobe is a single-cycle pulse
        ad_d       = ad_q;
        din_d      = din_q;
        ack_data_d = ack_data_q;
        ok_d       = ok_q;
        len_ext    = {1'b0, rx_data, len_lo_q};

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == MAGIC)) begin
                    state_d = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                if (rx_valid) begin
                    if ((len_ext == 17'd0) || (len_ext > MAX_LEN)) begin
                        ack_data_d = ACK_ERR;
                        ok_d       = 1'b0;
                        state_d    = ST_ACK;
                    end else begin
                        len_d      = len_ext[CNT_W-1:0];
                        word_cnt_d = '0;
                        byte_idx_d = '0;
                        csum_d     = 8'd0;
                        state_d    = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    csum_d     = csum_q + rx_data;
                    // Bytes arrive LSB first, so shifting each new byte in at
                    // the top leaves the first byte in the lowest lane.
                    word_d     = {rx_data, word_q[23:8]};
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == BYTE_IDX_W'(3)) begin
                        wre_d      = 1'b1;
                        ad_d       = word_cnt_q[ADDR_W-1:0];
                        din_d      = {rx_data, word_q};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_d == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end

            ST_CSUM: begin
                if (rx_valid) begin
                    ok_d       = (rx_data == csum_q);
                    ack_data_d = (rx_data == csum_q) ? ACK_OK : ACK_ERR;
                    state_d    = ST_ACK;
                end
            end

            ST_ACK: begin
                // Incoming bytes are dropped until the status is taken.
                if (ack_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_lo_q   <= 8'd0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= 8'd0;
            word_q     <= 24'd0;
            wre_q      <= 1'b0;
            ad_q       <= '0;
            din_q      <= 32'd0;
            ack_data_q <= 8'd0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            wre_q      <= wre_d;
            ad_q       <= ad_d;
            din_q      <= din_d;
            ack_data_q <= ack_data_d;
            ok_q       <= ok_d;
        end
    end

    assign mem_wre   = wre_q;
    assign mem_ce    = wre_q;
    assign mem_ad    = ad_q;
    assign mem_din   = din_q;
    assign ack_valid = (state_q == ST_ACK);
    assign ack_data  = ack_data_q;
    assign cpu_hold  = (state_q != ST_IDLE);
    assign load_done = ack_valid && ack_ready && ok_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader: a per-cycle vector table covering the
// basic frame shapes, plus hand-written sequences for a full-memory load
// with status back-pressure and a reset in the middle of a frame.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_ce;
    logic        mem_wre;
    logic [10:0] mem_ad;
    logic [31:0] mem_din;
    logic        ack_valid;
    logic [7:0]  ack_data;
    logic        ack_ready;
    logic        cpu_hold;
    logic        load_done;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_ce    (mem_ce),
        .mem_wre   (mem_wre),
        .mem_ad    (mem_ad),
        .mem_din   (mem_din),
        .ack_valid (ack_valid),
        .ack_data  (ack_data),
        .ack_ready (ack_ready),
        .cpu_hold  (cpu_hold),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic ld_seen;

    // Write monitor: mirrors every memory write into a bench-side memory.
    logic [31:0] model_mem [0:2047];
    int wr_total     = 0;
    int addr0_total  = 0;
    int ce_bad_total = 0;

    always @(negedge clk) begin
        if (mem_wre === 1'b1) begin
            wr_total          <= wr_total + 1;
            model_mem[mem_ad] <= mem_din;
            if (mem_ad == 11'd0) addr0_total <= addr0_total + 1;
        end
        if (mem_ce !== mem_wre) ce_bad_total <= ce_bad_total + 1;
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        wre;
        logic [10:0] ad;
        logic [31:0] din;
        logic        av;
        logic [7:0]  ack;
        logic        hold;
        logic        ld;
    } vec_t;

    vec_t tbl[$];

    task automatic a(input logic v, input logic [7:0] d, input logic rdy,
                     input logic wre, input logic [10:0] ad, input logic [31:0] din,
                     input logic av, input logic [7:0] ack, input logic hold,
                     input logic ld);
        vec_t e;
        e.v = v; e.d = d; e.rdy = rdy; e.wre = wre; e.ad = ad; e.din = din;
        e.av = av; e.ack = ack; e.hold = hold; e.ld = ld;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, sample load_done mid-cycle (it is
    // combinational on ack_ready), then land 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic rst);
        rx_valid  = v;
        rx_data   = d;
        ack_ready = rdy;
        reset     = rst;
        @(negedge clk);
        ld_seen = load_done;
        @(posedge clk);
        #1;
        rx_valid  = 1'b0;
        ack_ready = 1'b0;
        reset     = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return {i[7:0] ^ 8'hA5, 5'b0, i[10:8], ~i[7:0], i[7:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr;
        int base_a0;
        int bad;
        logic [7:0]  sum;
        logic [31:0] wd;
        logic [7:0]  byt;

        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mem_wre",   {31'd0, mem_wre},   32'd0);
        chk("rst_mem_ce",    {31'd0, mem_ce},    32'd0);
        chk("rst_mem_ad",    {21'd0, mem_ad},    32'd0);
        chk("rst_mem_din",   mem_din,            32'd0);
        chk("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("rst_ack_data",  {24'd0, ack_data},  32'd0);
        chk("rst_cpu_hold",  {31'd0, cpu_hold},  32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);

        // Frame 1: valid 2-word load; data byte sum = 0x97.
        a(1,8'hA5,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h02,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h00,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h13,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h05,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h10,0, 0,11'd0,32'h0,        0,8'h00,1,0);
        a(1,8'h00,0, 1,11'd0,32'h00100513, 0,8'h00,1,0);
        a(1,8'h6F,0, 0,11'd0,32'h00100513, 0,8'h00,1,0);
        a(1,8'h00,0, 0,11'd0,32'h00100513, 0,8'h00,1,0);
        a(1,8'h00,0, 0,11'd0,32'h00100513, 0,8'h00,1,0);
        a(1,8'h00,0, 1,11'd1,32'h0000006F, 0,8'h00,1,0);
        a(1,8'h97,0, 0,11'd1,32'h0000006F, 1,8'h4B,1,0);
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 1,8'h4B,1,0);  // rx ignored in ACK
        a(0,8'h00,1, 0,11'd1,32'h0000006F, 0,8'h4B,0,1);
        a(0,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h4B,0,0);  // no strobe, no start
        // Frame 2: same data, wrong checksum 0x98.
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h02,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h00,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h13,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h05,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h10,0, 0,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h00,0, 1,11'd0,32'h00100513, 0,8'h4B,1,0);
        a(1,8'h6F,0, 0,11'd0,32'h00100513, 0,8'h4B,1,0);
        a(1,8'h00,0, 0,11'd0,32'h00100513, 0,8'h4B,1,0);
        a(1,8'h00,0, 0,11'd0,32'h00100513, 0,8'h4B,1,0);
        a(1,8'h00,0, 1,11'd1,32'h0000006F, 0,8'h4B,1,0);
        a(1,8'h98,0, 0,11'd1,32'h0000006F, 1,8'h45,1,0);
        a(0,8'h00,1, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        // Frame 3: len 0, then len 0x0801 (> 2048).
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h00,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h00,0, 0,11'd1,32'h0000006F, 1,8'h45,1,0);
        a(0,8'h00,1, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h01,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h08,0, 0,11'd1,32'h0000006F, 1,8'h45,1,0);
        a(0,8'h00,1, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        // Frame 4: noise, then 1 word whose first byte equals MAGIC; sum 0x0B.
        a(1,8'h00,0, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        a(1,8'hFF,0, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        a(1,8'h3C,0, 0,11'd1,32'h0000006F, 0,8'h45,0,0);
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h01,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h00,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'hA5,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h11,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h22,0, 0,11'd1,32'h0000006F, 0,8'h45,1,0);
        a(1,8'h33,0, 1,11'd0,32'h332211A5, 0,8'h45,1,0);
        a(1,8'h0B,0, 0,11'd0,32'h332211A5, 1,8'h4B,1,0);
        a(0,8'h00,1, 0,11'd0,32'h332211A5, 0,8'h4B,0,1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
            $display("vec %0d: rx_valid=%b rx_data=%h ack_ready=%b -> wre=%b ad=%h din=%h av=%b ack=%h hold=%b ld=%b",
                     i, tbl[i].v, tbl[i].d, tbl[i].rdy, mem_wre, mem_ad, mem_din,
                     ack_valid, ack_data, cpu_hold, ld_seen);
            chk($sformatf("vec%0d_mem_wre", i),   {31'd0, mem_wre},   {31'd0, tbl[i].wre});
            chk($sformatf("vec%0d_mem_ce", i),    {31'd0, mem_ce},    {31'd0, tbl[i].wre});
            chk($sformatf("vec%0d_mem_ad", i),    {21'd0, mem_ad},    {21'd0, tbl[i].ad});
            chk($sformatf("vec%0d_mem_din", i),   mem_din,            tbl[i].din);
            chk($sformatf("vec%0d_ack_valid", i), {31'd0, ack_valid}, {31'd0, tbl[i].av});
            chk($sformatf("vec%0d_ack_data", i),  {24'd0, ack_data},  {24'd0, tbl[i].ack});
            chk($sformatf("vec%0d_cpu_hold", i),  {31'd0, cpu_hold},  {31'd0, tbl[i].hold});
            chk($sformatf("vec%0d_load_done", i), {31'd0, ld_seen},   {31'd0, tbl[i].ld});
        end

        // Full 2048-word load, one byte per cycle, then ack back-pressure.
        base_wr = wr_total;
        base_a0 = addr0_total;
        step(1, 8'hA5, 0, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h08, 0, 0);
        chk("full_len_accepted_hold", {31'd0, cpu_hold},  32'd1);
        chk("full_len_accepted_av",   {31'd0, ack_valid}, 32'd0);
        sum = 8'd0;
        for (int w = 0; w < 2048; w++) begin
            wd = word_of(w);
            for (int b = 0; b < 4; b++) begin
                byt = wd[8*b +: 8];
                sum = sum + byt;
                step(1, byt, 0, 0);
            end
        end
        step(1, sum, 0, 0);
        chk("full_ack_valid", {31'd0, ack_valid}, 32'd1);
        chk("full_ack_data",  {24'd0, ack_data},  32'h4B);
        for (int k = 0; k < 10; k++) begin
            step(0, 8'h00, 0, 0);
            chk($sformatf("bp%0d_ack_valid", k), {31'd0, ack_valid}, 32'd1);
            chk($sformatf("bp%0d_ack_data", k),  {24'd0, ack_data},  32'h4B);
            chk($sformatf("bp%0d_load_done", k), {31'd0, ld_seen},   32'd0);
        end
        step(0, 8'h00, 1, 0);
        chk("full_load_done", {31'd0, ld_seen},   32'd1);
        chk("full_hold_low",  {31'd0, cpu_hold},  32'd0);
        chk("full_av_low",    {31'd0, ack_valid}, 32'd0);
        chk("full_wr_count",  wr_total - base_wr,    32'd2048);
        chk("full_addr0_wr",  addr0_total - base_a0, 32'd1);
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (model_mem[i] !== word_of(i)) bad++;
        end
        chk("full_mem_contents_bad", bad, 32'd0);
        $display("full load: writes=%0d addr0_writes=%0d bad_words=%0d",
                 wr_total - base_wr, addr0_total - base_a0, bad);

        // Reset after the second data byte of word 0.
        base_wr = wr_total;
        step(1, 8'hA5, 0, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h13, 0, 0);
        step(1, 8'h05, 0, 0);
        chk("mid_hold_before", {31'd0, cpu_hold}, 32'd1);
        step(0, 8'h00, 0, 1);
        chk("mid_rst_mem_wre",   {31'd0, mem_wre},   32'd0);
        chk("mid_rst_mem_ad",    {21'd0, mem_ad},    32'd0);
        chk("mid_rst_mem_din",   mem_din,            32'd0);
        chk("mid_rst_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("mid_rst_ack_data",  {24'd0, ack_data},  32'd0);
        chk("mid_rst_cpu_hold",  {31'd0, cpu_hold},  32'd0);
        step(1, 8'h10, 0, 0);   // leftover byte in IDLE is ignored
        chk("mid_no_writes", wr_total - base_wr, 32'd0);
        chk("mid_idle_hold", {31'd0, cpu_hold}, 32'd0);
        // Reload: word 0x12345678, sum 0x14.
        step(1, 8'hA5, 0, 0);
        step(1, 8'h01, 0, 0);
        step(1, 8'h00, 0, 0);
        step(1, 8'h78, 0, 0);
        step(1, 8'h56, 0, 0);
        step(1, 8'h34, 0, 0);
        step(1, 8'h12, 0, 0);
        chk("reload_mem_wre", {31'd0, mem_wre}, 32'd1);
        chk("reload_mem_ad",  {21'd0, mem_ad},  32'd0);
        chk("reload_mem_din", mem_din,          32'h12345678);
        step(1, 8'h14, 0, 0);
        chk("reload_mem_wre_off", {31'd0, mem_wre},   32'd0);
        chk("reload_ack_valid",   {31'd0, ack_valid}, 32'd1);
        chk("reload_ack_data",    {24'd0, ack_data},  32'h4B);
        step(0, 8'h00, 1, 0);
        chk("reload_load_done", {31'd0, ld_seen},  32'd1);
        chk("reload_hold_low",  {31'd0, cpu_hold}, 32'd0);
        chk("reload_wr_count",  wr_total - base_wr, 32'd1);
        $display("reset mid-frame and reload: writes=%0d", wr_total - base_wr);

        chk("mem_ce_tracks_wre", ce_bad_total, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
